uart_rx_fifo: RTL and testbench

UART receive front end that consumes the board-level RsRx serial line inside TOP. It turns the serial line into bytes for the on-chip UART register block. It oversamples the line at 16x baud, validates start and stop bits, and buffers received bytes in a show-ahead FIFO with a valid/ready output. Framing and overrun conditions are reported as single-cycle pulses.

---
 rtl/uart_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled start/data/stop framing into a show-ahead byte FIFO.
// Framing errors and dropped bytes are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_resetn,
    input  logic                          RsRx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx;
    logic [DIV_W-1:0] r_div;
    logic [3:0]      r_smp;
    logic [2:0]      r_bit;
    logic            r_s7;
    logic            r_s8;
    logic [7:0]      r_shift;
    logic            r_push;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_tick;
    logic            w_mid;
    logic            w_end;
    logic            w_maj;
    logic            w_push_c;
    logic            w_ferr_c;
    logic            w_shift_c;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [CW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_rd_ptr;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_rx   = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_W'(DIV - 1));
    assign w_mid  = w_tick && (r_smp == 4'd9);
    assign w_end  = w_tick && (r_smp == 4'd15);
    assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

    // State register
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx) w_next = S_START;
            S_START: begin
                if (w_mid && w_maj) w_next = S_IDLE;
                else if (w_end)     w_next = S_DATA;
            end
            S_DATA:  if (w_end && (r_bit == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_mid) w_next = w_maj ? S_IDLE : S_BRK;
            S_BRK:   if (w_rx) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-state strobes
    always_comb begin
        w_push_c  = 1'b0;
        w_ferr_c  = 1'b0;
        w_shift_c = 1'b0;
        case (r_state)
            S_DATA: w_shift_c = w_mid;
            S_STOP: begin
                w_push_c = w_mid && w_maj;
                w_ferr_c = w_mid && !w_maj;
            end
            default: ;
        endcase
    end

    // Synchronizer, baud/sample counters, shift register; counters held clear in IDLE
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_div       <= '0;
            r_smp       <= '0;
            r_bit       <= '0;
            r_s7        <= 1'b0;
            r_s8        <= 1'b0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1 <= RsRx;
            r_sync2 <= r_sync1;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_smp <= '0;
                r_bit <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
                if (w_tick) begin
                    r_smp <= r_smp + 4'd1;
                    if (r_smp == 4'd7) r_s7 <= w_rx;
                    if (r_smp == 4'd8) r_s8 <= w_rx;
                    if ((r_state == S_DATA) && (r_smp == 4'd15)) r_bit <= r_bit + 3'd1;
                end
            end
            if (w_shift_c) r_shift <= {w_maj, r_shift[7:1]};
            r_push      <= w_push_c;
            r_frame_err <= w_ferr_c;
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == CW'(FIFO_DEPTH));
    assign w_pop   = rx_valid && rx_ready;
    assign w_wr    = r_push && (!w_full || w_pop);

    // Show-ahead FIFO; a push into a full FIFO only succeeds alongside a pop
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
            r_overrun <= r_push && w_full && !w_pop;
        end
    end

    assign rx_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign rx_valid   = (w_count != '0);
    assign fifo_count = w_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo at 16 clocks per bit, 4-entry FIFO;
// a queue stands in for the FIFO when predicting data, occupancy and overruns.
module tb_uart_rx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_resetn;
    logic       RsRx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int n_tests  = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    logic [7:0] model_q[$];

    uart_rx_fifo #(
        .CLK_FREQ  (1843200),
        .BAUD      (115200),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_resetn(sys_resetn),
        .RsRx      (RsRx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .fifo_count(fifo_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse-width counters: one count per high cycle
    always @(negedge sys_clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 10-bit frame; samples rx_valid 1 and 2 cycles after the stop-bit decision
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pop_at_push,
                              output logic v_before, output logic v_after);
        RsRx = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 8; i++) begin
            RsRx = d[i];
            repeat (16) step();
        end
        RsRx = stop_b;
        repeat (13) step();
        v_before = rx_valid;
        if (pop_at_push) rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        v_after = rx_valid;
        repeat (2) step();
        RsRx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        logic       vb;
        logic       va;
        logic [7:0] d;
        int         bad;
        int         f0;
        int         o0;
        int         exp_ovr;

        sys_resetn = 1'b0;
        RsRx       = 1'b1;
        rx_ready   = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_data",  32'(rx_data), 0);
        check("rst_ferr",  32'(frame_err), 0);
        check("rst_ovr",   32'(overrun), 0);
        sys_resetn = 1'b1;

        bad = 0;
        repeat (500) begin
            step();
            if (rx_valid || frame_err || overrun || (fifo_count != 3'd0)) bad++;
        end
        check("idle_quiet", 32'(bad), 0);

        // Single byte, exact show-ahead latency
        send_frame(8'hA5, 1'b1, 1'b0, vb, va);
        check("a5_lat_early", 32'(vb), 0);
        check("a5_lat_valid", 32'(va), 1);
        check("a5_data",  32'(rx_data), 32'h A5);
        check("a5_count", 32'(fifo_count), 1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("a5_pop_valid", 32'(rx_valid), 0);
        check("a5_pop_count", 32'(fifo_count), 0);

        // Short glitch is a false start
        f0 = ferr_cnt;
        RsRx = 1'b0;
        repeat (6) step();
        RsRx = 1'b1;
        repeat (48) step();
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_count", 32'(fifo_count), 0);
        check("glitch_ferr",  32'(ferr_cnt - f0), 0);

        // Bad stop bit followed by a long break, then a good byte
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, vb, va);
        RsRx = 1'b0;
        repeat (640) step();
        RsRx = 1'b1;
        repeat (32) step();
        send_frame(8'h7E, 1'b1, 1'b0, vb, va);
        check("brk_ferr_once", 32'(ferr_cnt - f0), 1);
        check("brk_data",  32'(rx_data), 32'h7E);
        check("brk_count", 32'(fifo_count), 1);
        pop_check("brk_drain", 8'h7E);

        // Five bytes into four entries
        o0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, vb, va);
        check("ovr_count", 32'(fifo_count), 4);
        check("ovr_pulse", 32'(ovr_cnt - o0), 1);
        for (int b = 1; b <= 4; b++) pop_check($sformatf("ovr_drain%0d", b), 8'(b));
        check("ovr_empty", 32'(fifo_count), 0);

        // Full FIFO with a pop coinciding with the push
        model_q.delete();
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0, vb, va);
            model_q.push_back(d);
        end
        check("full_count", 32'(fifo_count), 4);
        o0 = ovr_cnt;
        send_frame(8'h55, 1'b1, 1'b1, vb, va);
        void'(model_q.pop_front());
        model_q.push_back(8'h55);
        check("full_pp_count", 32'(fifo_count), 4);
        check("full_pp_ovr",   32'(ovr_cnt - o0), 0);
        for (int k = 0; k < 4; k++) pop_check($sformatf("full_pp_drain%0d", k), model_q[k]);
        model_q.delete();

        // Reset mid-frame with bytes queued
        for (int k = 0; k < 2; k++) send_frame(8'($urandom), 1'b1, 1'b0, vb, va);
        check("pre_rst_count", 32'(fifo_count), 2);
        d = 8'hF0;
        RsRx = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 3; i++) begin
            RsRx = d[i];
            repeat (16) step();
        end
        sys_resetn = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 0);
        check("midrst_count", 32'(fifo_count), 0);
        repeat (3) step();
        RsRx = 1'b1;
        sys_resetn = 1'b1;
        repeat (20) step();
        send_frame(8'h81, 1'b1, 1'b0, vb, va);
        check("postrst_data",  32'(rx_data), 32'h81);
        check("postrst_count", 32'(fifo_count), 1);
        pop_check("postrst_drain", 8'h81);

        // Random bytes with random draining against the queue model
        o0 = ovr_cnt;
        exp_ovr = 0;
        for (int it = 0; it < 10; it++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0, vb, va);
            if (model_q.size() < 4) model_q.push_back(d);
            else exp_ovr++;
            check($sformatf("rnd_count%0d", it), 32'(fifo_count), 32'(model_q.size()));
            if ($urandom_range(0, 1) == 1) begin
                pop_check($sformatf("rnd_pop%0d", it), model_q[0]);
                void'(model_q.pop_front());
            end
        end
        check("rnd_ovr", 32'(ovr_cnt - o0), 32'(exp_ovr));
        while (model_q.size() > 0) begin
            pop_check("rnd_drain", model_q[0]);
            void'(model_q.pop_front());
        end
        check("rnd_empty", 32'(rx_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
